// File: rtl/gs_pkg.sv
// Shared definitions for the gs_raw_signal_source slice: command opcodes,
// command word field positions and the capture FSM state encoding.
package gs_pkg;

  // Command opcodes carried in the top nibble of each 32-bit command word
  localparam logic [3:0] GS_OP_START = 4'h1;
  localparam logic [3:0] GS_OP_ABORT = 4'h2;

  // Command word field positions
  localparam int GS_OP_MSB  = 31;
  localparam int GS_OP_LSB  = 28;
  localparam int GS_CNT_MSB = 15;
  localparam int GS_CNT_LSB = 0;

  // Capture FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } gs_state_e;

  // Opcode field of a command word
  function automatic logic [3:0] gs_opcode(input logic [31:0] word);
    return word[GS_OP_MSB:GS_OP_LSB];
  endfunction

  // Sample-count field of a command word
  function automatic logic [15:0] gs_count(input logic [31:0] word);
    return word[GS_CNT_MSB:GS_CNT_LSB];
  endfunction

  // A START only means something when it asks for at least one sample
  function automatic logic gs_is_start(input logic [31:0] word);
    return (gs_opcode(word) == GS_OP_START) && (gs_count(word) != 16'd0);
  endfunction

  function automatic logic gs_is_abort(input logic [31:0] word);
    return gs_opcode(word) == GS_OP_ABORT;
  endfunction

endpackage

// File: rtl/gs_sync_fifo.sv
// Single-clock FIFO with registered (non fall-through) output.
// dout updates the cycle after a read that finds the FIFO non-empty.
// srst empties the FIFO and clears dout; it overrides any read or write.
module gs_sync_fifo #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          srst,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full  && !srst;
  assign rd_ok = rd_en && !empty && !srst;

  // Pointer and occupancy bookkeeping; a simultaneous read and write leaves count alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sample storage, no reset needed on the array itself
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  // Registered read data, cleared on reset and flush so nothing stale is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (srst) begin
      dout <= '0;
    end else if (rd_ok) begin
      dout <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/gs_raw_signal_source.sv
// FPGA-side producer for the xillybus gs_raw_signal read stream.
// Command words from gs_start_test arm a capture of N samples, which are
// buffered in gs_sync_fifo and served to the host read port with eof once
// the capture is finished and everything has been read.
// Build option: define GS_TEST_PATTERN_EN to capture an internal ramp
// (0x0000 upward from each START) instead of smp_data.
module gs_raw_signal_source
  import gs_pkg::*;
#(
  parameter int FIFO_AW  = 10,
  parameter int SAMPLE_W = 16
) (
  input  logic                bus_clk,
  input  logic                bus_rst_n,
  input  logic                cmd_wren,
  input  logic [31:0]         cmd_data,
  output logic                cmd_full,
  input  logic                cmd_open,
  input  logic                rd_rden,
  output logic                rd_empty,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_eof,
  input  logic                rd_open,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic                busy,
  output logic                overflow
);

  gs_state_e           state;
  gs_state_e           state_nxt;
  logic [15:0]         remaining;
  logic                overflow_r;

  logic                start_cmd;
  logic                abort_cmd;
  logic                start_acc;
  logic                capture_fire;
  logic                flush;

  logic                fifo_full;
  logic                fifo_empty;
  logic                wr_en_p0;
  logic [SAMPLE_W-1:0] wr_data_p0;
  logic                drop_p0;

  // Command decode; every word is consumed, so the write side never stalls
  assign cmd_full  = 1'b0;
  assign start_cmd = cmd_wren && gs_is_start(cmd_data);
  assign abort_cmd = cmd_wren && gs_is_abort(cmd_data);

  // A START only takes effect from IDLE with the read side open
  assign start_acc = rd_open && (state == IDLE) && start_cmd;

  // A sample is consumed in CAPTURE unless an ABORT lands in the same cycle
  assign capture_fire = rd_open && (state == CAPTURE) && smp_valid && !abort_cmd;

  // The FIFO is emptied whenever the host has the stream closed and at every new capture
  assign flush = !rd_open || start_acc;

  // Capture stage: consumed samples go to the FIFO unless it is full, in which case they are dropped
  assign wr_en_p0 = capture_fire && !fifo_full;
  assign drop_p0  = capture_fire &&  fifo_full;

`ifdef GS_TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] ramp;
  logic                unused_inputs;

  // Test ramp restarts at zero on each accepted START and advances per consumed strobe
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      ramp <= '0;
    end else if (start_acc) begin
      ramp <= '0;
    end else if (capture_fire) begin
      ramp <= ramp + 1'b1;
    end
  end

  assign wr_data_p0    = ramp;
  assign unused_inputs = ^{cmd_open, cmd_data[27:16], smp_data};
`else
  logic unused_inputs;

  assign wr_data_p0    = smp_data;
  assign unused_inputs = ^{cmd_open, cmd_data[27:16]};
`endif

  // Next-state logic; closing the read stream returns to IDLE from anywhere
  always_comb begin
    state_nxt = state;
    if (!rd_open) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_cmd) state_nxt = ARMED;
        end
        ARMED: begin
          state_nxt = abort_cmd ? DONE : CAPTURE;
        end
        CAPTURE: begin
          if (abort_cmd) begin
            state_nxt = DONE;
          end else if (capture_fire && (remaining == 16'd1)) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remaining-sample counter: loaded on START, counts every consumed strobe including dropped ones
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      remaining <= '0;
    end else if (start_acc) begin
      remaining <= gs_count(cmd_data);
    end else if (capture_fire) begin
      remaining <= remaining - 1'b1;
    end
  end

  // Sticky overflow: cleared only by a new capture, survives the stream being closed
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      overflow_r <= 1'b0;
    end else if (start_acc) begin
      overflow_r <= 1'b0;
    end else if (drop_p0) begin
      overflow_r <= 1'b1;
    end
  end

  gs_sync_fifo #(
    .AW (FIFO_AW),
    .DW (SAMPLE_W)
  ) u_fifo (
    .clk   (bus_clk),
    .rst_n (bus_rst_n),
    .srst  (flush),
    .wr_en (wr_en_p0),
    .din   (wr_data_p0),
    .full  (fifo_full),
    .rd_en (rd_rden),
    .dout  (rd_data),
    .empty (fifo_empty)
  );

  // Host-facing status; eof only once the capture is over and the FIFO has drained
  assign rd_empty = fifo_empty;
  assign rd_eof   = rd_open && (state == DONE) && fifo_empty;
  assign busy     = (state == ARMED) || (state == CAPTURE);
  assign overflow = overflow_r;

endmodule

// File: tb/tb_gs_raw_signal_source.sv
// Self-checking bench for gs_raw_signal_source (FIFO_AW=4, depth 16).
// Expected read-back is derived from the stimulus: each START begins a
// capture of N strobes, the first min(strobes, depth) values are buffered
// in order, extra strobes set overflow, and eof follows the last read.
module tb_gs_raw_signal_source;

  localparam int TB_AW = 4;
  localparam int DEPTH = 1 << TB_AW;

  logic        bus_clk;
  logic        bus_rst_n;
  logic        cmd_wren;
  logic [31:0] cmd_data;
  logic        cmd_full;
  logic        cmd_open;
  logic        rd_rden;
  logic        rd_empty;
  logic [15:0] rd_data;
  logic        rd_eof;
  logic        rd_open;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        busy;
  logic        overflow;

  int          n_checks;
  int          n_pass;
  logic [15:0] exp_q[$];
  int          model_occ;
  int          cap_idx;

  gs_raw_signal_source #(
    .FIFO_AW  (TB_AW),
    .SAMPLE_W (16)
  ) dut (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .cmd_wren  (cmd_wren),
    .cmd_data  (cmd_data),
    .cmd_full  (cmd_full),
    .cmd_open  (cmd_open),
    .rd_rden   (rd_rden),
    .rd_empty  (rd_empty),
    .rd_data   (rd_data),
    .rd_eof    (rd_eof),
    .rd_open   (rd_open),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Value the host should see for the idx-th consumed strobe of a capture
  function automatic logic [15:0] exp_val(input int idx, input logic [15:0] d);
`ifdef GS_TEST_PATTERN_EN
    return idx[15:0];
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    cmd_data = w;
    cmd_wren = 1'b1;
    tick();
    cmd_wren = 1'b0;
    cmd_data = $urandom;
  endtask

  // START with random don't-care bits; model begins a fresh capture
  task automatic send_start(input logic [15:0] n);
    logic [11:0] mid;
    mid = 12'($urandom);
    send_word({4'h1, mid, n});
    exp_q.delete();
    model_occ = 0;
    cap_idx   = 0;
  endtask

  // The cycle right after START: a strobe here must not be captured
  task automatic armed_cycle(input bit junk);
    smp_valid = junk;
    smp_data  = 16'($urandom);
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic push_one(input logic [15:0] d);
    smp_valid = 1'b1;
    smp_data  = d;
    tick();
    smp_valid = 1'b0;
    if (model_occ < DEPTH) begin
      exp_q.push_back(exp_val(cap_idx, d));
      model_occ++;
    end
    cap_idx++;
  endtask

  task automatic push_random(input int k, input bit gaps);
    for (int i = 0; i < k; i++) begin
      push_one(16'($urandom));
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  // Read everything the model expects, then require empty with eof
  task automatic drain(input string tag);
    logic [15:0] e;
    int          k;
    k = 0;
    while (exp_q.size() > 0) begin
      n_checks++;
      if (rd_empty !== 1'b0) $display("FAIL %s_nonempty[%0d]: rd_empty=%b required 0", tag, k, rd_empty);
      else n_pass++;
      rd_rden = 1'b1;
      tick();
      rd_rden = 1'b0;
      e = exp_q.pop_front();
      model_occ--;
      n_checks++;
      if (rd_data !== e) $display("FAIL %s_data[%0d]: rd_data=%h required %h", tag, k, rd_data, e);
      else n_pass++;
      k++;
    end
    n_checks++;
    if (rd_empty !== 1'b1) $display("FAIL %s_empty_end: rd_empty=%b required 1", tag, rd_empty);
    else n_pass++;
    n_checks++;
    if (rd_eof !== 1'b1) $display("FAIL %s_eof_end: rd_eof=%b required 1", tag, rd_eof);
    else n_pass++;
  endtask

  task automatic cycle_port();
    rd_open = 1'b0;
    tick();
    rd_open = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus_rst_n = 1'b0;
    cmd_wren = 1'b0; cmd_data = '0; cmd_open = 1'b1;
    rd_rden = 1'b0; rd_open = 1'b0; smp_valid = 1'b0; smp_data = '0;
    tick();
    tick();
    n_checks++;
    if (rd_empty !== 1'b1) $display("FAIL reset_empty: rd_empty=%b required 1", rd_empty); else n_pass++;
    n_checks++;
    if (rd_data !== 16'h0) $display("FAIL reset_data: rd_data=%h required 0000", rd_data); else n_pass++;
    n_checks++;
    if (rd_eof !== 1'b0) $display("FAIL reset_eof: rd_eof=%b required 0", rd_eof); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b required 0", busy); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: overflow=%b required 0", overflow); else n_pass++;
    n_checks++;
    if (cmd_full !== 1'b0) $display("FAIL reset_cmd_full: cmd_full=%b required 0", cmd_full); else n_pass++;
    bus_rst_n = 1'b1;
    rd_open   = 1'b1;
    tick();
  endtask

  // Words that must not start a capture from IDLE
  task automatic test_ignored_cmds();
    send_word({4'h1, 12'h0, 16'h0000});
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ign_start_n0: busy=%b required 0", busy); else n_pass++;
    send_word({4'h3, 12'hABC, 16'h0005});
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ign_opcode3: busy=%b required 0", busy); else n_pass++;
    send_word({4'h2, 28'h0});
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ign_abort_idle: busy=%b required 0", busy); else n_pass++;
    n_checks++;
    if (rd_eof !== 1'b0) $display("FAIL ign_abort_eof: rd_eof=%b required 0", rd_eof); else n_pass++;
  endtask

  task automatic test_basic();
    send_start(16'd4);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy_armed: busy=%b required 1", busy); else n_pass++;
    armed_cycle(1'b1);
    for (int i = 0; i < 4; i++) push_one(16'hA001 + 16'(i));
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_done: busy=%b required 0", busy); else n_pass++;
    n_checks++;
    if (rd_eof !== 1'b0) $display("FAIL basic_eof_pending: rd_eof=%b required 0", rd_eof); else n_pass++;
    // START outside IDLE is ignored and leaves the buffered data alone
    send_start_ignored(16'd5);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_start_in_done: busy=%b required 0", busy); else n_pass++;
    drain("basic");
    cycle_port();
  endtask

  task automatic send_start_ignored(input logic [15:0] n);
    send_word({4'h1, 12'h000, n});
  endtask

  task automatic test_random_capture();
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 12);
      send_start(16'(n));
      armed_cycle(1'($urandom));
      push_random(n, 1'b1);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rand%0d_busy: busy=%b required 0", it, busy); else n_pass++;
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL rand%0d_overflow: overflow=%b required 0", it, overflow); else n_pass++;
      drain($sformatf("rand%0d", it));
      cycle_port();
    end
  endtask

  task automatic test_overflow();
    send_start(16'(DEPTH + 4));
    armed_cycle(1'b0);
    push_random(DEPTH + 4, 1'b0);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_set: overflow=%b required 1", overflow); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ovf_done: busy=%b required 0", busy); else n_pass++;
    drain("ovf");
    rd_open = 1'b0;
    tick();
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_retained: overflow=%b required 1", overflow); else n_pass++;
    rd_open = 1'b1;
    tick();
    send_start(16'd1);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_cleared: overflow=%b required 0", overflow); else n_pass++;
    armed_cycle(1'b0);
    push_random(1, 1'b0);
    drain("ovf_next");
    cycle_port();
  endtask

  task automatic test_abort();
    send_start(16'd100);
    armed_cycle(1'b1);
    push_random(10, 1'b1);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL abort_busy_before: busy=%b required 1", busy); else n_pass++;
    // ABORT with a coincident strobe that must not be buffered
    smp_valid = 1'b1;
    smp_data  = 16'($urandom);
    send_word({4'h2, 28'($urandom)});
    smp_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_busy_after: busy=%b required 0", busy); else n_pass++;
    n_checks++;
    if (rd_eof !== 1'b0) $display("FAIL abort_eof_pending: rd_eof=%b required 0", rd_eof); else n_pass++;
    drain("abort");
    cycle_port();
  endtask

  // Reads and writes in the same cycles; occupancy stays at one
  task automatic test_back_to_back();
    logic [15:0] d;
    logic [15:0] e;
    bit          do_rd;
    send_start(16'd8);
    armed_cycle(1'b0);
    for (int i = 0; i < 8; i++) begin
      do_rd     = (model_occ > 0);
      d         = 16'($urandom);
      rd_rden   = do_rd;
      smp_valid = 1'b1;
      smp_data  = d;
      tick();
      rd_rden   = 1'b0;
      smp_valid = 1'b0;
      if (do_rd) begin
        e = exp_q.pop_front();
        model_occ--;
        n_checks++;
        if (rd_data !== e) $display("FAIL b2b_data[%0d]: rd_data=%h required %h", i, rd_data, e);
        else n_pass++;
      end
      exp_q.push_back(exp_val(cap_idx, d));
      cap_idx++;
      model_occ++;
    end
    drain("b2b");
    cycle_port();
  endtask

  task automatic test_close_mid_capture();
    send_start(16'd50);
    armed_cycle(1'b0);
    push_random(3, 1'b0);
    rd_open = 1'b0;
    n_checks++;
    if (rd_eof !== 1'b0) $display("FAIL close_eof_same: rd_eof=%b required 0", rd_eof); else n_pass++;
    tick();
    n_checks++;
    if (rd_empty !== 1'b1) $display("FAIL close_empty: rd_empty=%b required 1", rd_empty); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL close_busy: busy=%b required 0", busy); else n_pass++;
    n_checks++;
    if (rd_eof !== 1'b0) $display("FAIL close_eof: rd_eof=%b required 0", rd_eof); else n_pass++;
    send_start_ignored(16'd3);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL close_start_ignored: busy=%b required 0", busy); else n_pass++;
    rd_open = 1'b1;
    tick();
    send_start(16'd2);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL close_restart: busy=%b required 1", busy); else n_pass++;
    armed_cycle(1'b0);
    push_random(2, 1'b1);
    drain("close_restart");
    cycle_port();
  endtask

  task automatic test_async_reset();
    send_start(16'd30);
    armed_cycle(1'b0);
    push_random(DEPTH + 4, 1'b0);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL arst_pre_overflow: overflow=%b required 1", overflow); else n_pass++;
    #2;
    bus_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_empty, rd_data, rd_eof, busy, overflow} !== {1'b1, 16'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL arst_outputs: empty=%b data=%h eof=%b busy=%b ovf=%b required 1/0000/0/0/0",
               rd_empty, rd_data, rd_eof, busy, overflow);
    else n_pass++;
    tick();
    n_checks++;
    if ({rd_empty, busy, overflow} !== 3'b100)
      $display("FAIL arst_held: empty=%b busy=%b ovf=%b required 1/0/0", rd_empty, busy, overflow);
    else n_pass++;
    bus_rst_n = 1'b1;
    tick();
    rd_rden = 1'b1;
    tick();
    rd_rden = 1'b0;
    n_checks++;
    if (rd_data !== 16'h0) $display("FAIL arst_no_stale: rd_data=%h required 0000", rd_data); else n_pass++;
    n_checks++;
    if (rd_empty !== 1'b1) $display("FAIL arst_empty_after: rd_empty=%b required 1", rd_empty); else n_pass++;
    push_one(16'h1234);
    n_checks++;
    if (rd_empty !== 1'b1) $display("FAIL arst_idle_sample: rd_empty=%b required 1", rd_empty); else n_pass++;
    exp_q.delete();
    model_occ = 0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    model_occ = 0;
    cap_idx   = 0;
    test_reset();
    test_ignored_cmds();
    test_basic();
    test_random_capture();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_close_mid_capture();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
